bolucu: RTL and testbench



---
 rtl/bolucu_pkg.sv | 26 ++
 rtl/bolucu_toplayici.sv | 38 +++
 rtl/bolucu.sv | 127 ++++++++++++
 tb/tb_bolucu.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bolucu_pkg.sv
// Shared encodings and constants for the bolucu iterative divider.
// Operation codes mirror the RV32M funct3 low bits for DIV/DIVU/REM/REMU.
package bolucu_pkg;

  localparam logic [1:0] BOL_DIV  = 2'b00;
  localparam logic [1:0] BOL_DIVU = 2'b01;
  localparam logic [1:0] BOL_REM  = 2'b10;
  localparam logic [1:0] BOL_REMU = 2'b11;

  localparam logic [1:0] BOSTA  = 2'd0;
  localparam logic [1:0] BOL    = 2'd1;
  localparam logic [1:0] DUZELT = 2'd2;
  localparam logic [1:0] SONUC  = 2'd3;

  localparam int unsigned BOL_ADIM    = 32;
  localparam int unsigned BOL_GECIKME = 34;

  function automatic logic isaretli(input logic [1:0] islem);
    return ~islem[0];
  endfunction

  function automatic logic kalan_mi(input logic [1:0] islem);
    return islem[1];
  endfunction

endpackage

// File: rtl/bolucu_toplayici.sv
// toplayici: 32-bit Kogge-Stone prefix adder with carry in/out.
// Used by bolucu for the trial subtraction of each restoring step.
module toplayici (
  input  logic [31:0] islec0_i,
  input  logic [31:0] islec1_i,
  input  logic        carry_i,
  output logic [31:0] toplam_o,
  output logic        carry_o
);

  logic [31:0] w_g [6];
  logic [31:0] w_p [6];
  logic [32:0] w_c;

  always_comb begin
    w_g[0] = islec0_i & islec1_i;
    w_p[0] = islec0_i ^ islec1_i;
    for (int unsigned s = 1; s < 6; s++) begin
      for (int unsigned i = 0; i < 32; i++) begin
        if (i >= (32'd1 << (s - 1))) begin
          w_g[s][i] = w_g[s-1][i] | (w_p[s-1][i] & w_g[s-1][i - (32'd1 << (s - 1))]);
          w_p[s][i] = w_p[s-1][i] & w_p[s-1][i - (32'd1 << (s - 1))];
        end else begin
          w_g[s][i] = w_g[s-1][i];
          w_p[s][i] = w_p[s-1][i];
        end
      end
    end
    // Group terms span down to bit 0, so carry_i folds in with one AND-OR per bit.
    w_c[0] = carry_i;
    for (int unsigned i = 0; i < 32; i++) begin
      w_c[i+1] = w_g[5][i] | (w_p[5][i] & carry_i);
    end
    toplam_o = w_p[0] ^ w_c[31:0];
    carry_o  = w_c[32];
  end

endmodule

// File: rtl/bolucu.sv
// bolucu: iterative restoring divider for RV32M DIV/DIVU/REM/REMU,
// one quotient bit per cycle, valid/ready on both request and result.
module bolucu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            istek_gecerli_i,
  output logic            istek_hazir_o,
  input  logic [1:0]      islem_i,
  input  logic [XLEN-1:0] bolunen_i,
  input  logic [XLEN-1:0] bolen_i,
  output logic            sonuc_gecerli_o,
  input  logic            sonuc_hazir_i,
  output logic [XLEN-1:0] sonuc_o
);
  import bolucu_pkg::*;

  logic [1:0]      r_durum;
  logic [1:0]      r_islem;
  logic [XLEN-1:0] r_bolen;
  logic [XLEN-1:0] r_kalan;
  logic [XLEN-1:0] r_bolum;
  logic [XLEN-1:0] r_sonuc;
  logic [5:0]      r_sayac;
  logic            r_q_neg;
  logic            r_r_neg;

  logic            w_isaretli;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_sifir;
  logic            w_tasma;
  logic [XLEN-1:0] w_r_kay;
  logic            w_r_ust;
  logic [XLEN-1:0] w_bolen_tumler;
  logic [XLEN-1:0] w_fark;
  logic            w_carry;
  logic            w_borcsuz;
  logic [XLEN-1:0] w_secim;
  logic            w_negatif;
  logic [XLEN-1:0] w_duzeltilmis;

  assign w_isaretli = isaretli(islem_i);
  assign w_abs_a    = (w_isaretli & bolunen_i[XLEN-1]) ? ~bolunen_i + 1'b1 : bolunen_i;
  assign w_abs_b    = (w_isaretli & bolen_i[XLEN-1])   ? ~bolen_i + 1'b1   : bolen_i;
  assign w_sifir    = (bolen_i == '0);
  assign w_tasma    = w_isaretli && (bolunen_i == {1'b1, {(XLEN-1){1'b0}}}) && (bolen_i == '1);

  // Shifted-out MSB of R means R' >= 2^32 > divisor, so the step cannot borrow.
  assign w_r_ust        = r_kalan[XLEN-1];
  assign w_r_kay        = {r_kalan[XLEN-2:0], r_bolum[XLEN-1]};
  assign w_bolen_tumler = ~r_bolen;
  assign w_borcsuz      = w_r_ust | w_carry;

  toplayici u_toplayici (
    .islec0_i (w_r_kay),
    .islec1_i (w_bolen_tumler),
    .carry_i  (1'b1),
    .toplam_o (w_fark),
    .carry_o  (w_carry)
  );

  assign w_secim       = kalan_mi(r_islem) ? r_kalan : r_bolum;
  assign w_negatif     = isaretli(r_islem) & (kalan_mi(r_islem) ? r_r_neg : r_q_neg);
  assign w_duzeltilmis = w_negatif ? ~w_secim + 1'b1 : w_secim;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOSTA;
      r_islem <= '0;
      r_bolen <= '0;
      r_kalan <= '0;
      r_bolum <= '0;
      r_sonuc <= '0;
      r_sayac <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else begin
      case (r_durum)
        BOSTA: begin
          if (istek_gecerli_i) begin
            r_islem <= islem_i;
            if (w_sifir) begin
              r_sonuc <= kalan_mi(islem_i) ? bolunen_i : '1;
              r_durum <= SONUC;
            end else if (w_tasma) begin
              r_sonuc <= kalan_mi(islem_i) ? '0 : bolunen_i;
              r_durum <= SONUC;
            end else begin
              r_bolen <= w_abs_b;
              r_bolum <= w_abs_a;
              r_kalan <= '0;
              r_sayac <= '0;
              r_q_neg <= w_isaretli & (bolunen_i[XLEN-1] ^ bolen_i[XLEN-1]);
              r_r_neg <= w_isaretli & bolunen_i[XLEN-1];
              r_durum <= BOL;
            end
          end
        end
        BOL: begin
          r_kalan <= w_borcsuz ? w_fark : w_r_kay;
          r_bolum <= {r_bolum[XLEN-2:0], w_borcsuz};
          r_sayac <= r_sayac + 6'd1;
          if (r_sayac == 6'(BOL_ADIM - 1)) begin
            r_durum <= DUZELT;
          end
        end
        DUZELT: begin
          r_sonuc <= w_duzeltilmis;
          r_durum <= SONUC;
        end
        SONUC: begin
          if (sonuc_hazir_i) begin
            r_durum <= BOSTA;
          end
        end
        default: r_durum <= BOSTA;
      endcase
    end
  end

  assign istek_hazir_o   = (r_durum == BOSTA);
  assign sonuc_gecerli_o = (r_durum == SONUC);
  assign sonuc_o         = r_sonuc;

endmodule

// File: tb/tb_bolucu.sv
// Directed and randomized self-checking bench for the bolucu divider.
module tb_bolucu;
  import bolucu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        istek_gecerli_i = 1'b0;
  logic        istek_hazir_o;
  logic [1:0]  islem_i = 2'b00;
  logic [31:0] bolunen_i = '0;
  logic [31:0] bolen_i = '0;
  logic        sonuc_gecerli_o;
  logic        sonuc_hazir_i = 1'b0;
  logic [31:0] sonuc_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    int          lat;
  } vec_t;

  bolucu #(.XLEN(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .istek_gecerli_i (istek_gecerli_i),
    .istek_hazir_o   (istek_hazir_o),
    .islem_i         (islem_i),
    .bolunen_i       (bolunen_i),
    .bolen_i         (bolen_i),
    .sonuc_gecerli_o (sonuc_gecerli_o),
    .sonuc_hazir_i   (sonuc_hazir_i),
    .sonuc_o         (sonuc_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      BOL_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      BOL_REM:  begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      BOL_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one request, waits (bounded) for the result, holds the consumer
  // off for 'stall' cycles, then completes the result handshake.
  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, output logic [31:0] res, output int lat);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (istek_hazir_o === 1'b1) break;
    end
    islem_i = op; bolunen_i = a; bolen_i = b; istek_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    istek_gecerli_i = 1'b0;
    islem_i = 2'($urandom); bolunen_i = $urandom; bolen_i = $urandom;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk_i);
      if (sonuc_gecerli_o === 1'b1) break;
    end
    lat = k;
    repeat (stall) @(negedge clk_i);
    res = sonuc_o;
    sonuc_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    sonuc_hazir_i = 1'b0;
  endtask

  task automatic run_vectors(input string name, input vec_t v[]);
    logic [31:0] res;
    int lat;
    for (int i = 0; i < v.size(); i++) begin
      run_req(v[i].op, v[i].a, v[i].b, 0, res, lat);
      n_checks++;
      if (res !== v[i].q) begin
        n_fail++;
        $display("FAIL %s[%0d] sonuc: got %h want %h", name, i, res, v[i].q);
      end
      n_checks++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (istek_hazir_o !== 1'b1) begin n_fail++; $display("FAIL reset_istek_hazir: got %b want 1", istek_hazir_o); end
    n_checks++;
    if (sonuc_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL reset_sonuc_gecerli: got %b want 0", sonuc_gecerli_o); end
    n_checks++;
    if (sonuc_o !== 32'h0) begin n_fail++; $display("FAIL reset_sonuc: got %h want 00000000", sonuc_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_unsigned();
    vec_t v[] = new[6];
    v[0] = '{BOL_DIVU, 32'd100,         32'd7,  32'd14,          BOL_GECIKME};
    v[1] = '{BOL_REMU, 32'd100,         32'd7,  32'd2,           BOL_GECIKME};
    v[2] = '{BOL_DIVU, 32'hFFFF_FFFF,   32'd1,  32'hFFFF_FFFF,   BOL_GECIKME};
    v[3] = '{BOL_REMU, 32'hFFFF_FFFF,   32'd16, 32'hF,           BOL_GECIKME};
    v[4] = '{BOL_DIVU, 32'd5,           32'd9,  32'd0,           BOL_GECIKME};
    v[5] = '{BOL_REMU, 32'd5,           32'd9,  32'd5,           BOL_GECIKME};
    run_vectors("unsigned", v);
  endtask

  task automatic test_signed();
    vec_t v[] = new[8];
    v[0] = '{BOL_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, BOL_GECIKME};
    v[1] = '{BOL_REM, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, BOL_GECIKME};
    v[2] = '{BOL_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, BOL_GECIKME};
    v[3] = '{BOL_REM, 32'd7,         32'hFFFF_FFFE, 32'd1,         BOL_GECIKME};
    v[4] = '{BOL_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         BOL_GECIKME};
    v[5] = '{BOL_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, BOL_GECIKME};
    v[6] = '{BOL_DIV, 32'h8000_0000, 32'd1,         32'h8000_0000, BOL_GECIKME};
    v[7] = '{BOL_REM, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE, BOL_GECIKME};
    run_vectors("signed", v);
  endtask

  task automatic test_div_zero();
    vec_t v[] = new[4];
    v[0] = '{BOL_DIVU, 32'h1234,      32'd0, 32'hFFFF_FFFF, 1};
    v[1] = '{BOL_REMU, 32'h1234,      32'd0, 32'h1234,      1};
    v[2] = '{BOL_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1};
    v[3] = '{BOL_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1};
    run_vectors("div_zero", v);
  endtask

  task automatic test_overflow();
    vec_t v[] = new[4];
    v[0] = '{BOL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[1] = '{BOL_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
    v[2] = '{BOL_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         BOL_GECIKME};
    v[3] = '{BOL_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, BOL_GECIKME};
    run_vectors("overflow", v);
  endtask

  task automatic test_backpressure();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (istek_hazir_o === 1'b1) break;
    end
    islem_i = BOL_DIVU; bolunen_i = 32'd1000; bolen_i = 32'd10; istek_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    istek_gecerli_i = 1'b0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk_i);
      if (sonuc_gecerli_o === 1'b1) break;
    end
    n_checks++;
    if (k !== BOL_GECIKME) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", k, BOL_GECIKME); end
    // A competing request stays asserted while the result is stalled.
    islem_i = BOL_DIVU; bolunen_i = 32'd50; bolen_i = 32'd5; istek_gecerli_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      n_checks++;
      if (sonuc_o !== 32'd100) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h want %h", c, sonuc_o, 32'd100); end
      n_checks++;
      if (istek_hazir_o !== 1'b0) begin n_fail++; $display("FAIL bp_istek_hazir[%0d]: got %b want 0", c, istek_hazir_o); end
      n_checks++;
      if (sonuc_gecerli_o !== 1'b1) begin n_fail++; $display("FAIL bp_gecerli[%0d]: got %b want 1", c, sonuc_gecerli_o); end
    end
    istek_gecerli_i = 1'b0;
    sonuc_hazir_i = 1'b1;
    @(posedge clk_i); #1;
    sonuc_hazir_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (istek_hazir_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_hazir: got %b want 1", istek_hazir_o); end
    n_checks++;
    if (sonuc_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL bp_release_gecerli: got %b want 0", sonuc_gecerli_o); end
    @(negedge clk_i);
    n_checks++;
    if (istek_hazir_o !== 1'b1) begin n_fail++; $display("FAIL bp_no_accept: got %b want 1", istek_hazir_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    int seen;
    @(negedge clk_i);
    islem_i = BOL_DIVU; bolunen_i = 32'hDEAD_BEEF; bolen_i = 32'd3; istek_gecerli_i = 1'b1;
    @(posedge clk_i); #1;
    istek_gecerli_i = 1'b0;
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_checks++;
    if (sonuc_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL midrst_gecerli: got %b want 0", sonuc_gecerli_o); end
    n_checks++;
    if (sonuc_o !== 32'h0) begin n_fail++; $display("FAIL midrst_sonuc: got %h want 00000000", sonuc_o); end
    n_checks++;
    if (istek_hazir_o !== 1'b1) begin n_fail++; $display("FAIL midrst_hazir: got %b want 1", istek_hazir_o); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (sonuc_gecerli_o !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midrst_ghost_result: got %0d valid cycles want 0", seen); end
    run_req(BOL_DIVU, 32'd9, 32'd3, 0, res, lat);
    n_checks++;
    if (res !== 32'd3) begin n_fail++; $display("FAIL midrst_after: got %h want %h", res, 32'd3); end
    n_checks++;
    if (lat !== BOL_GECIKME) begin n_fail++; $display("FAIL midrst_after_lat: got %0d want %0d", lat, BOL_GECIKME); end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] want;
    int lat;
    int want_lat;
    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 20));
        4: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      want = model(op, a, b);
      want_lat = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : BOL_GECIKME;
      run_req(op, a, b, $urandom_range(0, 3), res, lat);
      n_checks++;
      if (res !== want) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h want %h", n, op, a, b, res, want);
      end
      n_checks++;
      if (lat !== want_lat) begin
        n_fail++;
        $display("FAIL random_lat[%0d]: got %0d want %0d", n, lat, want_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
